// File: rtl/twiddle_mul0.sv
`default_nettype none
// ============================================================================
//  Module   : twiddle_mul0
//  Purpose  : Twiddle multiplier for the difference half of a radix-2 step-0
//             butterfly. The sum half passes through bit-exact; both halves
//             have a 2-cycle latency. The twiddle ROM is built at elaboration
//             from an integer Taylor-series cos/sin.
//  Revision : 1.0  initial release
// ============================================================================
module twiddle_mul0 #(
  parameter int LANES = 16,
  parameter int NFFT  = 512,
  parameter int IN_W  = 13,
  parameter int TW_W  = 10
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  din_valid,
  input  logic [LANES*IN_W-1:0] din_add_r,
  input  logic [LANES*IN_W-1:0] din_add_i,
  input  logic [LANES*IN_W-1:0] din_sub_r,
  input  logic [LANES*IN_W-1:0] din_sub_i,
  output logic                  dout_valid,
  output logic                  dout_frame_start,
  output logic [LANES*IN_W-1:0] dout_add_r,
  output logic [LANES*IN_W-1:0] dout_add_i,
  output logic [LANES*IN_W-1:0] dout_sub_r,
  output logic [LANES*IN_W-1:0] dout_sub_i
);

  localparam int NBLK  = NFFT / LANES;
  localparam int BLK_W = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int QTR   = NFFT / 4;
  localparam int PP_W  = IN_W + TW_W;      // single partial product
  localparam int PW    = IN_W + TW_W + 1;  // sum of two partial products
  localparam int TAB_W = NBLK * 2 * TW_W;

  // pi scaled by 2^48; all table maths is done in Q48 fixed point
  localparam logic signed [127:0] c_PI48 = 128'sd884279719003555;
  localparam logic signed [PW-1:0] c_SMAX = PW'((2 ** (IN_W - 1)) - 1);
  localparam logic signed [PW-1:0] c_SMIN = PW'(-(2 ** (IN_W - 1)));
  localparam logic [BLK_W-1:0]     c_BLK_LAST = BLK_W'(NBLK - 1);

  // Taylor series of cos or sin in Q48 for 0 <= th < pi/2
  function automatic logic signed [127:0] taylor(input logic signed [127:0] th,
                                                  input logic do_sin);
    logic signed [127:0] th2;
    logic signed [127:0] term;
    logic signed [127:0] acc;
    logic signed [127:0] den;
    int base;
    th2  = (th * th) >>> 48;
    term = do_sin ? th : (128'sd1 <<< 48);
    acc  = term;
    for (int m = 1; m < 14; m++) begin
      base = do_sin ? 2 * m : 2 * m - 1;
      den  = 128'(base * (base + 1));
      term = -(((term * th2) >>> 48) / den);
      acc  = acc + term;
    end
    return acc;
  endfunction

  // round(256 * v) for a non-negative Q48 value
  function automatic int rnd256(input logic signed [127:0] v);
    logic signed [127:0] t;
    t = (v + (128'sd1 <<< 39)) >>> 40;
    return int'(t);
  endfunction

  // {Wr, Wi} for index n; the first quadrant is computed, the rest mirrored
  function automatic logic [2*TW_W-1:0] twiddle(input int n);
    int q;
    int k;
    int c;
    int s;
    int wr;
    int wi;
    logic signed [127:0] th;
    q  = n / QTR;
    k  = n % QTR;
    th = (128'(k) * c_PI48 * 128'sd2) / 128'(NFFT);
    c  = rnd256(taylor(th, 1'b0));
    s  = rnd256(taylor(th, 1'b1));
    case (q)
      0:       begin wr =  c; wi = -s; end
      1:       begin wr = -s; wi = -c; end
      2:       begin wr = -c; wi =  s; end
      default: begin wr =  s; wi =  c; end
    endcase
    return {wr[TW_W-1:0], wi[TW_W-1:0]};
  endfunction

  // All NBLK twiddles a given lane will ever use, indexed by block
  function automatic logic [TAB_W-1:0] lane_tab(input int lane);
    logic [TAB_W-1:0] tab;
    tab = '0;
    for (int b = 0; b < NBLK; b++) begin
      tab[b*2*TW_W +: 2*TW_W] = twiddle(b * LANES + lane);
    end
    return tab;
  endfunction

  // Clamp a rounded product into the signed output range
  function automatic logic [IN_W-1:0] sat(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] t;
    if (v > c_SMAX) begin
      t = c_SMAX;
    end else if (v < c_SMIN) begin
      t = c_SMIN;
    end else begin
      t = v;
    end
    return t[IN_W-1:0];
  endfunction

  logic [BLK_W-1:0]      r_blk;
  logic                  r_v1;
  logic                  r_fs1;
  logic [LANES*IN_W-1:0] r_add_r1;
  logic [LANES*IN_W-1:0] r_add_i1;

  // Block counter and the valid / frame-start pipeline
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_blk            <= '0;
      r_v1             <= 1'b0;
      r_fs1            <= 1'b0;
      dout_valid       <= 1'b0;
      dout_frame_start <= 1'b0;
    end else begin
      if (din_valid) begin
        r_blk <= (r_blk == c_BLK_LAST) ? '0 : r_blk + 1'b1;
      end
      r_v1             <= din_valid;
      r_fs1            <= din_valid && (r_blk == '0);
      dout_valid       <= r_v1;
      dout_frame_start <= r_fs1;
    end
  end

  // Sum half: two valid-gated register stages, data untouched
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_add_r1   <= '0;
      r_add_i1   <= '0;
      dout_add_r <= '0;
      dout_add_i <= '0;
    end else begin
      if (din_valid) begin
        r_add_r1 <= din_add_r;
        r_add_i1 <= din_add_i;
      end
      if (r_v1) begin
        dout_add_r <= r_add_r1;
        dout_add_i <= r_add_i1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam logic [TAB_W-1:0] c_TAB = lane_tab(g);

    logic [2*TW_W-1:0]      w_tw;
    logic signed [TW_W-1:0] w_wr;
    logic signed [TW_W-1:0] w_wi;
    logic signed [IN_W-1:0] w_xr;
    logic signed [IN_W-1:0] w_xi;
    logic signed [PP_W-1:0] r_prr;
    logic signed [PP_W-1:0] r_pii;
    logic signed [PP_W-1:0] r_pri;
    logic signed [PP_W-1:0] r_pir;
    logic signed [PW-1:0]   w_re;
    logic signed [PW-1:0]   w_im;
    logic signed [PW-1:0]   w_re_s;
    logic signed [PW-1:0]   w_im_s;
    logic [IN_W-1:0]        r_out_r;
    logic [IN_W-1:0]        r_out_i;

    assign w_tw = c_TAB[r_blk*(2*TW_W) +: 2*TW_W];
    assign w_wr = w_tw[2*TW_W-1:TW_W];
    assign w_wi = w_tw[TW_W-1:0];
    assign w_xr = din_sub_r[g*IN_W +: IN_W];
    assign w_xi = din_sub_i[g*IN_W +: IN_W];

    // Stage 1: the four full-width partial products
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_prr <= '0;
        r_pii <= '0;
        r_pri <= '0;
        r_pir <= '0;
      end else if (din_valid) begin
        r_prr <= w_xr * w_wr;
        r_pii <= w_xi * w_wi;
        r_pri <= w_xr * w_wi;
        r_pir <= w_xi * w_wr;
      end
    end

    // Combine, round half up and drop the Q8 fraction
    assign w_re   = PW'(r_prr) - PW'(r_pii);
    assign w_im   = PW'(r_pri) + PW'(r_pir);
    assign w_re_s = (w_re + PW'(128)) >>> 8;
    assign w_im_s = (w_im + PW'(128)) >>> 8;

    // Stage 2: saturated result register
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_out_r <= '0;
        r_out_i <= '0;
      end else if (r_v1) begin
        r_out_r <= sat(w_re_s);
        r_out_i <= sat(w_im_s);
      end
    end

    assign dout_sub_r[g*IN_W +: IN_W] = r_out_r;
    assign dout_sub_i[g*IN_W +: IN_W] = r_out_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_twiddle_mul0.sv
`default_nettype none
// ============================================================================
//  Module   : tb_twiddle_mul0
//  Purpose  : Randomised scoreboard bench for twiddle_mul0 with a real-math
//             reference model of the twiddle product.
//  Revision : 1.0  initial release
// ============================================================================
module tb_twiddle_mul0;
  localparam int LANES = 16;
  localparam int NFFT  = 512;
  localparam int IN_W  = 13;
  localparam int TW_W  = 10;
  localparam int NBLK  = NFFT / LANES;
  localparam int W     = LANES * IN_W;

  logic         clk = 1'b0;
  logic         rstn;
  logic         din_valid;
  logic [W-1:0] din_add_r, din_add_i, din_sub_r, din_sub_i;
  logic         dout_valid, dout_frame_start;
  logic [W-1:0] dout_add_r, dout_add_i, dout_sub_r, dout_sub_i;

  twiddle_mul0 #(.LANES(LANES), .NFFT(NFFT), .IN_W(IN_W), .TW_W(TW_W)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid),
    .din_add_r(din_add_r), .din_add_i(din_add_i),
    .din_sub_r(din_sub_r), .din_sub_i(din_sub_i),
    .dout_valid(dout_valid), .dout_frame_start(dout_frame_start),
    .dout_add_r(dout_add_r), .dout_add_i(dout_add_i),
    .dout_sub_r(dout_sub_r), .dout_sub_i(dout_sub_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ar, ai, sr, si;
    bit           fs;
    int           cyc;
  } row_t;

  row_t         q[$];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           m_blk = 0;
  logic         rst_q = 1'b0;
  logic [W-1:0] h_ar = '0, h_ai = '0, h_sr = '0, h_si = '0;

  // Cycle count and the reset level the DUT saw at each edge
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rstn;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rnd_away(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(-x + 0.5);
  endfunction

  function automatic int scale_sat(input int v);
    int t;
    t = (v + 128) >>> 8;
    if (t > 4095) t = 4095;
    if (t < -4096) t = -4096;
    return t;
  endfunction

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    int           x;
    for (int l = 0; l < LANES; l++) begin
      case ($urandom_range(0, 9))
        0:       x = 4095;
        1:       x = -4096;
        default: x = int'($urandom);
      endcase
      v[l*IN_W +: IN_W] = x[IN_W-1:0];
    end
    return v;
  endfunction

  // Issue one row; the model predicts its output and queues it
  task automatic send_row(input logic [W-1:0] ar, ai, sr, si);
    row_t e;
    int   xr, xi, wr, wi, re, im, n;
    real  ang;
    din_valid = 1'b1;
    din_add_r = ar; din_add_i = ai; din_sub_r = sr; din_sub_i = si;
    if (rstn) begin
      e.ar = ar; e.ai = ai;
      e.fs = (m_blk == 0);
      e.cyc = cyc + 2;
      for (int l = 0; l < LANES; l++) begin
        n   = m_blk * LANES + l;
        ang = 2.0 * 3.14159265358979323846 * n / NFFT;
        wr  = rnd_away(256.0 * $cos(ang));
        wi  = rnd_away(-256.0 * $sin(ang));
        xr  = $signed(sr[l*IN_W +: IN_W]);
        xi  = $signed(si[l*IN_W +: IN_W]);
        re  = scale_sat(xr * wr - xi * wi);
        im  = scale_sat(xr * wi + xi * wr);
        e.sr[l*IN_W +: IN_W] = re[IN_W-1:0];
        e.si[l*IN_W +: IN_W] = im[IN_W-1:0];
      end
      q.push_back(e);
      m_blk = (m_blk + 1) % NBLK;
    end
    @(posedge clk); #1;
  endtask

  task automatic send_rand();
    send_row(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b0;
      din_add_r = rnd_vec(); din_add_i = rnd_vec();
      din_sub_r = rnd_vec(); din_sub_i = rnd_vec();
      @(posedge clk); #1;
    end
  endtask

  // Reset with din_valid held high; rows not yet out are discarded
  task automatic do_reset(input int n);
    rstn = 1'b0;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    m_blk = 0;
    for (int i = 0; i < n; i++) send_rand();
    rstn = 1'b1;
  endtask

  // Monitor: compare each presented row against the scoreboard head
  always @(negedge clk) begin
    row_t e;
    if (!rst_q) begin
      chk("rst_valid", dout_valid, 0);
      chk("rst_fs", dout_frame_start, 0);
      chk("rst_data", {dout_add_r, dout_add_i, dout_sub_r, dout_sub_i} != '0, 0);
      h_ar = '0; h_ai = '0; h_sr = '0; h_si = '0;
    end else if (dout_valid) begin
      chk("row_pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("latency_cycle", cyc, e.cyc);
        chk("frame_start", dout_frame_start, e.fs);
        chk("add_r", dout_add_r, e.ar);
        chk("add_i", dout_add_i, e.ai);
        chk("sub_r", dout_sub_r, e.sr);
        chk("sub_i", dout_sub_i, e.si);
        h_ar = e.ar; h_ai = e.ai; h_sr = e.sr; h_si = e.si;
      end
    end else begin
      chk("idle_fs", dout_frame_start, 0);
      chk("hold_add_r", dout_add_r, h_ar);
      chk("hold_add_i", dout_add_i, h_ai);
      chk("hold_sub_r", dout_sub_r, h_sr);
      chk("hold_sub_i", dout_sub_i, h_si);
    end
  end

  initial begin
    logic [W-1:0] ar, ai, sr, si;
    int           v;
    rstn = 1'b0;
    din_valid = 1'b1;
    din_add_r = rnd_vec(); din_add_i = rnd_vec();
    din_sub_r = rnd_vec(); din_sub_i = rnd_vec();
    @(posedge clk); #1;
    do_reset(2);
    idle(2);

    // First frame with directed lane-0 rows at blk 0, 4 and 8
    for (int b = 0; b < NBLK; b++) begin
      ar = rnd_vec(); ai = rnd_vec(); sr = rnd_vec(); si = rnd_vec();
      if (b == 0) begin
        v = 1000; sr[IN_W-1:0] = v[IN_W-1:0];
        v = 0;    si[IN_W-1:0] = v[IN_W-1:0];
        v = -37;  ar[IN_W-1:0] = v[IN_W-1:0];
        v = 5;    ai[IN_W-1:0] = v[IN_W-1:0];
      end else if (b == 4) begin
        v = 4095; sr[IN_W-1:0] = v[IN_W-1:0]; si[IN_W-1:0] = v[IN_W-1:0];
      end else if (b == 8) begin
        v = 100; sr[IN_W-1:0] = v[IN_W-1:0];
        v = 0;   si[IN_W-1:0] = v[IN_W-1:0];
      end
      send_row(ar, ai, sr, si);
      if (b != NBLK - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Back-to-back into a gapped frame: 16 rows, 5 idle, 16 rows, 1 more
    for (int i = 0; i < 16; i++) send_rand();
    idle(5);
    for (int i = 0; i < 17; i++) send_rand();
    idle(3);

    // Reset mid-frame, then resume with random gaps
    for (int i = 0; i < 10; i++) send_rand();
    do_reset(1);
    for (int i = 0; i < 40; i++) begin
      send_rand();
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 4));
    end
    idle(4);
    chk("drain_left", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
